// File: rtl/line_raster_pkg.sv
// Shared types and widths for the Bresenham line rasterizer.
package line_raster_pkg;
    localparam int X_W              = 11;
    localparam int Y_W              = 10;
    localparam int ERR_W            = 13;
    localparam int H_ACTIVE_DEFAULT = 1280;
    localparam int V_ACTIVE_DEFAULT = 720;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/bresenham_step.sv
// Combinational single Bresenham step: next (x, y, err, addr) from the current point.
module bresenham_step
    import line_raster_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int ADDR_W   = 20
) (
    input  logic [X_W-1:0]          cur_x_i,
    input  logic [Y_W-1:0]          cur_y_i,
    input  logic signed [ERR_W-1:0] err_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic signed [ERR_W-1:0] dx_i,
    input  logic signed [ERR_W-1:0] dy_i,
    input  logic                    sx_neg_i,
    input  logic                    sy_neg_i,
    output logic [X_W-1:0]          x_o,
    output logic [Y_W-1:0]          y_o,
    output logic signed [ERR_W-1:0] err_o,
    output logic [ADDR_W-1:0]       addr_o
);
    logic signed [ERR_W:0]   e2, dx_ext, dy_ext;
    logic                    step_x, step_y;
    logic signed [ERR_W-1:0] err_x;
    logic [ADDR_W-1:0]       addr_x;

    always_comb begin
        e2     = {err_i, 1'b0};
        dx_ext = {dx_i[ERR_W-1], dx_i};
        dy_ext = {dy_i[ERR_W-1], dy_i};
        step_x = (e2 >= dy_ext);
        step_y = (e2 <= dx_ext);

        // Both axis updates may apply in the same step; err accumulates both.
        err_x  = step_x ? err_i + dy_i : err_i;
        err_o  = step_y ? err_x + dx_i : err_x;

        x_o    = cur_x_i;
        addr_x = addr_i;
        if (step_x) begin
            x_o    = sx_neg_i ? cur_x_i - X_W'(1) : cur_x_i + X_W'(1);
            addr_x = sx_neg_i ? addr_i - ADDR_W'(1) : addr_i + ADDR_W'(1);
        end

        y_o    = cur_y_i;
        addr_o = addr_x;
        if (step_y) begin
            y_o    = sy_neg_i ? cur_y_i - Y_W'(1) : cur_y_i + Y_W'(1);
            addr_o = sy_neg_i ? addr_x - ADDR_W'(H_ACTIVE) : addr_x + ADDR_W'(H_ACTIVE);
        end
    end
endmodule

// File: rtl/line_raster_writer.sv
// Bresenham line rasterizer streaming pixel writes into a frame buffer.
// Optional LINE_RASTER_CLIP_EN suppresses pixels outside H_ACTIVE x V_ACTIVE.
//
// state | meaning
// IDLE  | ready for a line command
// SETUP | derive dx, dy, step signs, err and start address
// DRAW  | present current pixel; step on handshake
// DONE  | one-cycle done pulse
module line_raster_writer
    import line_raster_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int COLOR_W  = 24
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               line_valid_in,
    output logic               line_ready_out,
    input  logic [X_W-1:0]     x0_in,
    input  logic [Y_W-1:0]     y0_in,
    input  logic [X_W-1:0]     x1_in,
    input  logic [Y_W-1:0]     y1_in,
    input  logic [COLOR_W-1:0] color_in,
    output logic               pix_valid_out,
    input  logic               pix_ready_in,
    output logic [X_W-1:0]     pix_x_out,
    output logic [Y_W-1:0]     pix_y_out,
    output logic [ADDR_W-1:0]  pix_addr_out,
    output logic [COLOR_W-1:0] pix_color_out,
    output logic               done_out,
    output logic               busy_out
);
    state_e                  state_q, state_d;
    logic [X_W-1:0]          cur_x_q, x1_q, nx_x;
    logic [Y_W-1:0]          cur_y_q, y1_q, nx_y;
    logic signed [ERR_W-1:0] err_q, dx_q, dy_q, nx_err, dx_s, dy_s;
    logic [ADDR_W-1:0]       addr_q, nx_addr, addr_s;
    logic                    sx_neg_q, sy_neg_q;
    logic [COLOR_W-1:0]      color_q;
    logic                    at_end, clipped, step_fire;

    assign at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);
`ifdef LINE_RASTER_CLIP_EN
    assign clipped = (cur_x_q >= X_W'(H_ACTIVE)) || (cur_y_q >= Y_W'(V_ACTIVE));
`else
    assign clipped = 1'b0;
`endif
    // A clipped pixel advances without waiting for the frame buffer.
    assign step_fire = (state_q == DRAW) && (pix_ready_in || clipped);

    always_comb begin
        dx_s   = (x1_q >= cur_x_q) ? ERR_W'(x1_q - cur_x_q) : ERR_W'(cur_x_q - x1_q);
        dy_s   = ERR_W'(0) - ((y1_q >= cur_y_q) ? ERR_W'(y1_q - cur_y_q) : ERR_W'(cur_y_q - y1_q));
        addr_s = ADDR_W'(int'(cur_y_q) * H_ACTIVE + int'(cur_x_q));
    end

    bresenham_step #(.H_ACTIVE(H_ACTIVE), .ADDR_W(ADDR_W)) u_step (
        .cur_x_i (cur_x_q),
        .cur_y_i (cur_y_q),
        .err_i   (err_q),
        .addr_i  (addr_q),
        .dx_i    (dx_q),
        .dy_i    (dy_q),
        .sx_neg_i(sx_neg_q),
        .sy_neg_i(sy_neg_q),
        .x_o     (nx_x),
        .y_o     (nx_y),
        .err_o   (nx_err),
        .addr_o  (nx_addr)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_valid_in) state_d = SETUP;
            SETUP:   state_d = DRAW;
            DRAW:    if (step_fire && at_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_ready_out = (state_q == IDLE) && rst_in;
        pix_valid_out  = (state_q == DRAW) && !clipped;
        done_out       = (state_q == DONE);
        busy_out       = (state_q != IDLE);
        pix_x_out      = cur_x_q;
        pix_y_out      = cur_y_q;
        pix_addr_out   = addr_q;
        pix_color_out  = color_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            err_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            addr_q   <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            color_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (line_valid_in) begin
                    cur_x_q <= x0_in;
                    cur_y_q <= y0_in;
                    x1_q    <= x1_in;
                    y1_q    <= y1_in;
                    color_q <= color_in;
                end
                SETUP: begin
                    dx_q     <= dx_s;
                    dy_q     <= dy_s;
                    sx_neg_q <= (x1_q < cur_x_q);
                    sy_neg_q <= (y1_q < cur_y_q);
                    err_q    <= dx_s + dy_s;
                    addr_q   <= addr_s;
                end
                DRAW: if (step_fire && !at_end) begin
                    cur_x_q <= nx_x;
                    cur_y_q <= nx_y;
                    err_q   <= nx_err;
                    addr_q  <= nx_addr;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_line_raster_writer.sv
// Self-checking bench for line_raster_writer; reference rasterizer is a plain integer model.
module tb_line_raster_writer;
    localparam int H  = 1280;
    localparam int V  = 720;
    localparam int AW = 20;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        line_valid_in = 1'b0;
    logic        line_ready_out;
    logic [10:0] x0_in = '0, x1_in = '0;
    logic [9:0]  y0_in = '0, y1_in = '0;
    logic [23:0] color_in = '0;
    logic        pix_valid_out;
    logic        pix_ready_in = 1'b1;
    logic [10:0] pix_x_out;
    logic [9:0]  pix_y_out;
    logic [AW-1:0] pix_addr_out;
    logic [23:0] pix_color_out;
    logic        done_out, busy_out;

    line_raster_writer dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .line_valid_in(line_valid_in), .line_ready_out(line_ready_out),
        .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in), .color_in(color_in),
        .pix_valid_out(pix_valid_out), .pix_ready_in(pix_ready_in),
        .pix_x_out(pix_x_out), .pix_y_out(pix_y_out), .pix_addr_out(pix_addr_out),
        .pix_color_out(pix_color_out), .done_out(done_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int x; int y; int addr; int color; } pix_t;
    pix_t cap_q[$];
    pix_t exp_q[$];
    int   errors = 0, checks = 0;
    int   first_lat, done_k, last_hs_k, stall_seen, hold_bad;
    int   ready_in_done, ready_after, extra_act;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Textbook integer Bresenham; address taken by direct multiplication.
    task automatic build_model(input int ax0, ay0, ax1, ay1, col);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_q.delete();
        dx = iabs(ax1 - ax0); dy = -iabs(ay1 - ay0);
        sx = (ax1 >= ax0) ? 1 : -1; sy = (ay1 >= ay0) ? 1 : -1;
        err = dx + dy; x = ax0; y = ay0;
        forever begin
`ifdef LINE_RASTER_CLIP_EN
            if (x < H && y < V)
`endif
            exp_q.push_back('{x, y, (y * H + x) % (1 << AW), col});
            if (x == ax1 && y == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: stall 3 cycles at first x==1 pixel
    task automatic run_line(input int ax0, ay0, ax1, ay1, col, mode, input bit spam);
        int k, stalls; bit prev_stall, rdy; pix_t prev, cur;
        cap_q.delete();
        first_lat = -1; done_k = -1; last_hs_k = -1; hold_bad = 0; stalls = 0;
        ready_in_done = -1; ready_after = -1; extra_act = 0;
        prev = '{0, 0, 0, 0}; prev_stall = 0;
        @(negedge clk_in);
        x0_in = 11'(ax0); y0_in = 10'(ay0); x1_in = 11'(ax1); y1_in = 10'(ay1);
        color_in = 24'(col); line_valid_in = 1'b1; pix_ready_in = 1'b1;
        k = 0;
        while (!line_ready_out && k < 100) begin @(negedge clk_in); k++; end
        @(negedge clk_in);
        if (spam) begin
            x0_in = 11'd100; y0_in = 10'd100; x1_in = 11'd200; y1_in = 10'd150; color_in = 24'h123456;
        end else line_valid_in = 1'b0;
        k = 1;
        while (k < 10000) begin
            cur = '{int'(pix_x_out), int'(pix_y_out), int'(pix_addr_out), int'(pix_color_out)};
            if (prev_stall && (!pix_valid_out || cur.x != prev.x || cur.y != prev.y ||
                               cur.addr != prev.addr || cur.color != prev.color)) hold_bad++;
            if (done_out) begin done_k = k; ready_in_done = int'(line_ready_out); break; end
            if (pix_valid_out && first_lat < 0) first_lat = k;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && pix_valid_out && cur.x == 1 && stalls < 3) begin rdy = 1'b0; stalls++; end
            pix_ready_in = rdy;
            if (pix_valid_out && rdy) begin cap_q.push_back(cur); last_hs_k = k; end
            prev_stall = pix_valid_out && !rdy;
            prev = cur;
            @(negedge clk_in); k++;
        end
        stall_seen = stalls;
        line_valid_in = 1'b0; pix_ready_in = 1'b1;
        @(negedge clk_in);
        ready_after = int'(line_ready_out);
        for (int i = 0; i < 3; i++) begin
            if (busy_out || pix_valid_out || done_out) extra_act++;
            @(negedge clk_in);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({pix_valid_out, done_out, busy_out, line_ready_out} !== 4'b0 ||
            pix_x_out !== '0 || pix_y_out !== '0 || pix_addr_out !== '0 || pix_color_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got v=%b d=%b b=%b r=%b x=%0d y=%0d a=%0d c=%0h want all 0",
                pix_valid_out, done_out, busy_out, line_ready_out, pix_x_out, pix_y_out, pix_addr_out, pix_color_out);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (line_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got ready=%b busy=%b want 1 0", line_ready_out, busy_out);
        end
    endtask

    task automatic test_horizontal();
        int bad = 0;
        run_line(0, 0, 3, 0, 24'hA1B2C3, 0, 0);
        checks++;
        if (cap_q.size() != 4) begin errors++; $display("FAIL horiz_count: got %0d want 4", cap_q.size()); end
        for (int i = 0; i < cap_q.size() && i < 4; i++)
            if (cap_q[i].x != i || cap_q[i].y != 0 || cap_q[i].addr != i || cap_q[i].color != 24'hA1B2C3) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL horiz_pixels: got %0d bad pixels want 0", bad); end
        checks++;
        if (first_lat != 2) begin errors++; $display("FAIL horiz_latency: got %0d want 2", first_lat); end
        checks++;
        if (done_k != last_hs_k + 1) begin errors++; $display("FAIL horiz_done: got cycle %0d want %0d", done_k, last_hs_k + 1); end
        checks++;
        if (ready_in_done != 0 || ready_after != 1) begin
            errors++; $display("FAIL horiz_ready: got done=%0d after=%0d want 0 1", ready_in_done, ready_after);
        end
    endtask

    task automatic test_steep_reversed();
        int xs[6] = '{2, 2, 1, 1, 0, 0};
        int ys[6] = '{5, 4, 3, 2, 1, 0};
        int bad = 0;
        run_line(2, 5, 0, 0, 24'h00FF00, 0, 0);
        checks++;
        if (cap_q.size() != 6) begin errors++; $display("FAIL steep_count: got %0d want 6", cap_q.size()); end
        for (int i = 0; i < cap_q.size() && i < 6; i++)
            if (cap_q[i].x != xs[i] || cap_q[i].y != ys[i] || cap_q[i].addr != ys[i] * H + xs[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL steep_pixels: got %0d bad pixels want 0", bad); end
        checks++;
        if (cap_q.size() < 3 || cap_q[2].addr != 3841) begin
            errors++; $display("FAIL steep_addr13: got %0d want 3841", (cap_q.size() < 3) ? -1 : cap_q[2].addr);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        run_line(0, 0, 3, 0, 24'h0000FF, 2, 0);
        checks++;
        if (stall_seen != 3 || hold_bad != 0) begin
            errors++; $display("FAIL bp_hold: got stalls=%0d hold_bad=%0d want 3 0", stall_seen, hold_bad);
        end
        for (int i = 0; i < cap_q.size() && i < 4; i++)
            if (cap_q[i].x != i || cap_q[i].addr != i) bad++;
        checks++;
        if (cap_q.size() != 4 || bad != 0) begin
            errors++; $display("FAIL bp_sequence: got count=%0d bad=%0d want 4 0", cap_q.size(), bad);
        end
    endtask

    task automatic test_point();
        run_line(7, 9, 7, 9, 24'hFFFFFF, 0, 1);
        checks++;
        if (cap_q.size() != 1 || cap_q[0].addr != 11527 || cap_q[0].x != 7 || cap_q[0].y != 9) begin
            errors++; $display("FAIL point_pixel: got count=%0d addr=%0d want 1 11527",
                cap_q.size(), (cap_q.size() > 0) ? cap_q[0].addr : -1);
        end
        checks++;
        if (done_k != last_hs_k + 1) begin errors++; $display("FAIL point_done: got cycle %0d want %0d", done_k, last_hs_k + 1); end
        checks++;
        if (extra_act != 0) begin errors++; $display("FAIL point_ignore_busy_cmd: got %0d active cycles want 0", extra_act); end
    endtask

    task automatic test_reset_mid_line();
        int k = 0, bad = 0;
        @(negedge clk_in);
        x0_in = 11'd0; y0_in = 10'd0; x1_in = 11'd10; y1_in = 10'd4; color_in = 24'h777777;
        line_valid_in = 1'b1; pix_ready_in = 1'b1;
        @(negedge clk_in);
        line_valid_in = 1'b0;
        while (!(pix_valid_out && pix_x_out == 11'd2) && k < 50) begin @(negedge clk_in); k++; end
        checks++;
        if (k >= 50 || pix_y_out !== 10'd1) begin errors++; $display("FAIL rst_reach_pix3: got x=%0d y=%0d want 2 1", pix_x_out, pix_y_out); end
        #2 rst_in = 1'b0;
        #1;
        checks++;
        if ({pix_valid_out, done_out, busy_out, line_ready_out} !== 4'b0 ||
            pix_x_out !== '0 || pix_y_out !== '0 || pix_addr_out !== '0 || pix_color_out !== '0) begin
            errors++; $display("FAIL rst_async_outputs: got v=%b d=%b b=%b x=%0d a=%0d want all 0",
                pix_valid_out, done_out, busy_out, pix_x_out, pix_addr_out);
        end
        for (int i = 0; i < 3; i++) begin @(negedge clk_in); if (done_out || pix_valid_out) bad++; end
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk_in); if (done_out || pix_valid_out) bad++; end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles want 0", bad); end
        run_line(5, 5, 6, 6, 24'h010203, 0, 0);
        checks++;
        if (cap_q.size() != 2 || cap_q[0].addr != 6405 || cap_q[1].addr != 7686 || cap_q[1].x != 6 || cap_q[1].y != 6) begin
            errors++; $display("FAIL rst_next_line: got count=%0d want 2 pixels addr 6405,7686", cap_q.size());
        end
    endtask

    task automatic test_random();
        int ax0, ay0, ax1, ay1, col, n, bad, first_bad;
        for (int t = 0; t < 12; t++) begin
            if (t < 6) begin
                ax0 = $urandom_range(0, 40); ay0 = $urandom_range(0, 30);
                ax1 = $urandom_range(0, 40); ay1 = $urandom_range(0, 30);
            end else begin
                ax0 = $urandom_range(0, H - 1); ay0 = $urandom_range(0, V - 1);
                ax1 = $urandom_range(0, H - 1); ay1 = $urandom_range(0, V - 1);
            end
            col = $urandom_range(0, 32'hFFFFFF);
            build_model(ax0, ay0, ax1, ay1, col);
            run_line(ax0, ay0, ax1, ay1, col, 1, 0);
            n = ((iabs(ax1 - ax0) > iabs(ay1 - ay0)) ? iabs(ax1 - ax0) : iabs(ay1 - ay0)) + 1;
            checks++;
            if (cap_q.size() != n || exp_q.size() != n) begin
                errors++; $display("FAIL rand_count: line (%0d,%0d)-(%0d,%0d) got %0d want %0d", ax0, ay0, ax1, ay1, cap_q.size(), n);
            end
            bad = 0; first_bad = -1;
            for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
                if (cap_q[i].x != exp_q[i].x || cap_q[i].y != exp_q[i].y ||
                    cap_q[i].addr != exp_q[i].addr || cap_q[i].color != exp_q[i].color) begin
                    bad++; if (first_bad < 0) first_bad = i;
                end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand_pixels: line (%0d,%0d)-(%0d,%0d) got (%0d,%0d,a=%0d) want (%0d,%0d,a=%0d) at %0d",
                    ax0, ay0, ax1, ay1, cap_q[first_bad].x, cap_q[first_bad].y, cap_q[first_bad].addr,
                    exp_q[first_bad].x, exp_q[first_bad].y, exp_q[first_bad].addr, first_bad);
            end
            checks++;
            if (done_k != last_hs_k + 1 || hold_bad != 0) begin
                errors++; $display("FAIL rand_done_hold: got done=%0d hold_bad=%0d want %0d 0", done_k, hold_bad, last_hs_k + 1);
            end
        end
    endtask

`ifdef LINE_RASTER_CLIP_EN
    task automatic test_clip();
        run_line(1278, 10, 1282, 10, 24'hC0FFEE, 0, 0);
        checks++;
        if (cap_q.size() != 2 || cap_q[0].x != 1278 || cap_q[1].x != 1279) begin
            errors++; $display("FAIL clip_pixels: got count=%0d want 2 (x=1278,1279)", cap_q.size());
        end
        checks++;
        if (done_k < 0) begin errors++; $display("FAIL clip_done: got no done pulse want one"); end
    endtask
`endif

    initial begin
        test_reset();
        test_horizontal();
        test_steep_reversed();
        test_backpressure();
        test_point();
        test_reset_mid_line();
        test_random();
`ifdef LINE_RASTER_CLIP_EN
        test_clip();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
